pmod_da2_spi: RTL and testbench
===============================

// Module: pmod_da2_spi
// PURPOSE
//  Dual-channel SPI writer for the PmodDA2 (2x DAC121S101): it is the output counterpart of the AD1 reader.
//  - Accepts a pair of 12-bit samples through a valid/ready handshake.
//  - Serialises both samples as simultaneous 16-bit frames on dina/dinb, sharing one sync and one sclk.
//  - Sits between the sample-producing fabric logic and pmod_bridge pins (sync, dina, dinb, sclk).
// PARAMETERS
//  CLOCKS_PER_BIT               20   clk cycles per sclk period; even, >=2
//  CLOCKS_BEFORE_DATA           60   clk cycles from sync fall to first sclk rise
//  CLOCKS_AFTER_DATA            10   clk cycles from the last sclk rise (last bit) to sync rise
//  CLOCKS_BETWEEN_TRANSACTIONS  400  minimum sync-high clk cycles between frames; >=1
// PORTS
//  clk       in   1   system clock
//  rst       in   1   asynchronous, active-high reset
//  in_valid  in   1   sample pair valid
//  in_ready  out  1   block can accept a sample pair
//  data_a    in   12  channel A code (to dina)
//  data_b    in   12  channel B code (to dinb)
//  pd_mode   in   2   power-down bits PD1:PD0; present only with DA2_POWER_DOWN_EN
//  busy      out  1   a frame is in progress (any state other than IDLE)
//  done      out  1   one-cycle pulse when sync returns high
//  sync      out  1   active-low frame strobe (to DAC SYNC)
//  sclk      out  1   serial clock; idles high
//  dina      out  1   serial data, channel A
//  dinb      out  1   serial data, channel B
// BEHAVIOUR
//  Reset values: sync=1, sclk=1, dina=dinb=0, busy=0, done=0, in_ready=0, FSM=IDLE.
//  Reset mid-frame: all outputs return to their reset values at once; the partial frame is abandoned.
//  Frame format (MSB first): {2'b00, PD1, PD0, D11..D0}, 16 bits.
//  Handshake:
//   - in_ready=1 only in IDLE.
//   - A transfer happens when in_valid & in_ready on a clk edge.
//   - On transfer, the two 16-bit frames are latched into shift registers and the FSM enters SETUP on the same edge.
//   - Inputs are ignored while in_ready=0.
//  FSM:
//   - IDLE: sync=1, sclk=1. Transfer -> SETUP.
//   - SETUP: sync=0, sclk=1. Lasts CLOCKS_BEFORE_DATA cycles. Exit -> SHIFT.
//   - SHIFT: 16 bit periods of CLOCKS_PER_BIT cycles each.
//     - First half of a bit period: sclk=1. Second half: sclk=0.
//     - dina/dinb update on the first cycle of each bit period, so data is stable at the DAC's falling-edge sample.
//     - A 4-bit counter counts bits 15..0.
//     - After bit 0's period -> HOLD.
//   - HOLD: sync=0, sclk=1. Lasts CLOCKS_AFTER_DATA - CLOCKS_PER_BIT cycles (min 1). Exit -> GAP.
//     With defaults this is 10-20 -> the minimum of 1 cycle.
//   - GAP: sync=1, sclk=1, dina=dinb=0.
//     - done pulses on GAP entry.
//     - Lasts CLOCKS_BETWEEN_TRANSACTIONS cycles. Exit -> IDLE.
//  Latency: transfer to sync fall is 1 clk. Total frame cycles =
//   BEFORE + 16*PER_BIT + max(AFTER-PER_BIT,1) + BETWEEN.
//  Timing counter: sized by $clog2 of the largest parameter. It is reloaded on every state entry, so it never wraps.
//  Back-to-back: in_valid held high gives a new transfer on the first IDLE cycle, i.e. one sample pair per
//   (frame cycles + 1).
// CONFIGURATION
//  DA2_POWER_DOWN_EN defined:
//   - The pd_mode port exists.
//   - pd_mode is latched with the data on transfer and placed in frame bits 13:12 of both channels.
//  DA2_POWER_DOWN_EN undefined:
//   - No pd_mode port; PD bits are fixed 2'b00 (normal operation).
// STRUCTURE
//  Package pmod_da2_pkg:
//   - FSM state enum {IDLE,SETUP,SHIFT,HOLD,GAP}
//   - FRAME_BITS=16, DATA_BITS=12
//   - PD codes PD_NORMAL=2'b00, PD_1K=2'b01, PD_100K=2'b10, PD_HIZ=2'b11
//  Sub-module pmod_da2_bit_timer:
//   - Loadable down-counter with a terminal-count strobe and half-period sclk phase.
//   - Shared by SETUP/SHIFT/HOLD/GAP.
//  The shift registers and FSM stay in the top module.
// TESTING
//  Use CLOCKS_PER_BIT=4, BEFORE=6, AFTER=8, BETWEEN=5 unless stated.
//  1. Reset released, in_valid=0 for 50 cycles -> sync=1, sclk=1, dina=dinb=0, in_ready=1, busy=0.
//  2. data_a=12'hA5C, data_b=12'h3F0, one-cycle valid ->
//     - sync falls next cycle.
//     - 16 sclk falls.
//     - Bits captured at sclk falls: dina=16'h0A5C, dinb=16'h03F0.
//     - done pulses once; total frame cycles = 6+64+4+5.
//  3. in_valid held high with changing data ->
//     - Each accepted pair is serialised intact.
//     - Data changed while in_ready=0 never appears on dina/dinb.
//     - Sync-high gap >= 5 cycles.
//  4. rst asserted during SHIFT bit 7 ->
//     - sync=1, sclk=1, dina=0 combinationally after rst.
//     - After release the next transfer sends a full, correct frame.
//  5. DA2_POWER_DOWN_EN, pd_mode=2'b11, data_a=12'hFFF -> dina frame 16'h3FFF; without the macro -> 16'h0FFF.
//  6. CLOCKS_PER_BIT=2, data 12'h001/12'h800 -> sclk high and low each 1 cycle; frames 16'h0001 and 16'h0800.

Source files
------------

// File: rtl/pmod_da2_pkg.sv
// Shared types and constants for the PmodDA2 dual-DAC SPI writer.
package pmod_da2_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} da2_state_t;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // DAC121S101 frame: two don't-care zeros, power-down bits, then the code, MSB first.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0] pd,
                                                        input logic [DATA_BITS-1:0] code);
    return {2'b00, pd, code};
  endfunction

endpackage

// File: rtl/pmod_da2_bit_timer.sv
// Loadable down-counter shared by every timed phase of the DA2 writer.
// Also produces the registered sclk: high for the first half of each bit period.
module pmod_da2_bit_timer #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   HALF = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         sclk_en,
  output logic         tc,
  output logic         sclk
);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;
  logic         sclk_reg;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_value;
    end else if (count_reg != '0) begin
      count_next = count_reg - 1'b1;
    end
  end

  // sclk follows the count it will hold next cycle so it lines up with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      sclk_reg  <= 1'b1;
    end else begin
      count_reg <= count_next;
      sclk_reg  <= !sclk_en || (count_next >= HALF);
    end
  end

  assign tc   = (count_reg == '0);
  assign sclk = sclk_reg;

endmodule

// File: rtl/pmod_da2_spi.sv
// PmodDA2 writer: latches a pair of 12-bit codes and shifts two 16-bit frames out together.
// Build option DA2_POWER_DOWN_EN adds the pd_mode port and places it in frame bits 13:12.
module pmod_da2_spi
  import pmod_da2_pkg::*;
#(
  parameter int CLOCKS_PER_BIT              = 20,
  parameter int CLOCKS_BEFORE_DATA          = 60,
  parameter int CLOCKS_AFTER_DATA           = 10,
  parameter int CLOCKS_BETWEEN_TRANSACTIONS = 400
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] data_a,
  input  logic [DATA_BITS-1:0] data_b,
`ifdef DA2_POWER_DOWN_EN
  input  logic [1:0]           pd_mode,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 sync,
  output logic                 sclk,
  output logic                 dina,
  output logic                 dinb
);

  localparam int HOLD_CYCLES = (CLOCKS_AFTER_DATA > CLOCKS_PER_BIT) ?
                               (CLOCKS_AFTER_DATA - CLOCKS_PER_BIT) : 1;
  localparam int MAX_CLOCKS  = max_int(max_int(CLOCKS_PER_BIT, CLOCKS_BEFORE_DATA),
                                       max_int(HOLD_CYCLES, max_int(CLOCKS_BETWEEN_TRANSACTIONS, 2)));
  localparam int TIMER_W     = $clog2(MAX_CLOCKS);
  localparam int BIT_W       = $clog2(FRAME_BITS);

  // The timer is loaded with (duration - 1) and the state exits on the cycle it reads zero.
  localparam logic [TIMER_W-1:0] LOAD_BEFORE  = TIMER_W'(CLOCKS_BEFORE_DATA - 1);
  localparam logic [TIMER_W-1:0] LOAD_BIT     = TIMER_W'(CLOCKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] LOAD_HOLD    = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOAD_BETWEEN = TIMER_W'(CLOCKS_BETWEEN_TRANSACTIONS - 1);
  localparam logic [TIMER_W-1:0] HALF_BIT     = TIMER_W'(CLOCKS_PER_BIT / 2);

  da2_state_t            state_reg;
  logic [FRAME_BITS-1:0] shift_a_reg;
  logic [FRAME_BITS-1:0] shift_b_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic                  in_ready_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  sync_reg;
  logic                  dina_reg;
  logic                  dinb_reg;

  logic                  transfer;
  logic                  timer_tc;
  logic                  timer_load;
  logic [TIMER_W-1:0]    timer_value;
  logic                  sclk_en;
  logic                  bit_start;
  logic [1:0]            pd_bits;

`ifdef DA2_POWER_DOWN_EN
  assign pd_bits = pd_mode;
`else
  assign pd_bits = PD_NORMAL;
`endif

  assign transfer = in_valid && in_ready_reg;

  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    sclk_en     = 1'b0;
    bit_start   = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_load  = transfer;
        timer_value = LOAD_BEFORE;
      end
      SETUP: begin
        timer_load  = timer_tc;
        timer_value = LOAD_BIT;
        sclk_en     = timer_tc;
        bit_start   = timer_tc;
      end
      SHIFT: begin
        if (timer_tc && bit_cnt_reg == '0) begin
          timer_load  = 1'b1;
          timer_value = LOAD_HOLD;
        end else begin
          sclk_en     = 1'b1;
          timer_load  = timer_tc;
          timer_value = LOAD_BIT;
          bit_start   = timer_tc;
        end
      end
      HOLD: begin
        timer_load  = timer_tc;
        timer_value = LOAD_BETWEEN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_a_reg  <= '0;
      shift_b_reg  <= '0;
      bit_cnt_reg  <= '0;
      in_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      sync_reg     <= 1'b1;
      dina_reg     <= 1'b0;
      dinb_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bit_start) begin
        dina_reg    <= shift_a_reg[FRAME_BITS-1];
        dinb_reg    <= shift_b_reg[FRAME_BITS-1];
        shift_a_reg <= {shift_a_reg[FRAME_BITS-2:0], 1'b0};
        shift_b_reg <= {shift_b_reg[FRAME_BITS-2:0], 1'b0};
      end
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (transfer) begin
            shift_a_reg  <= build_frame(pd_bits, data_a);
            shift_b_reg  <= build_frame(pd_bits, data_b);
            state_reg    <= SETUP;
            sync_reg     <= 1'b0;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b0;
          end
        end
        SETUP: begin
          if (timer_tc) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= BIT_W'(FRAME_BITS - 1);
          end
        end
        SHIFT: begin
          if (timer_tc) begin
            if (bit_cnt_reg == '0) begin
              state_reg <= HOLD;
            end else begin
              bit_cnt_reg <= bit_cnt_reg - 1'b1;
            end
          end
        end
        HOLD: begin
          if (timer_tc) begin
            state_reg <= GAP;
            sync_reg  <= 1'b1;
            dina_reg  <= 1'b0;
            dinb_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        GAP: begin
          if (timer_tc) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            in_ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  pmod_da2_bit_timer #(
    .W    (TIMER_W),
    .HALF (HALF_BIT)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .sclk_en    (sclk_en),
    .tc         (timer_tc),
    .sclk       (sclk)
  );

  assign in_ready = in_ready_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign sync     = sync_reg;
  assign dina     = dina_reg;
  assign dinb     = dinb_reg;

endmodule

// File: tb/tb_pmod_da2_spi.sv
// Bench for pmod_da2_spi: two instances (4 and 2 clk per bit), cycle-level timing model plus frame table.
module tb_pmod_da2_spi;

  localparam int BEFORE  = 6;
  localparam int AFTER   = 8;
  localparam int BETWEEN = 5;
`ifdef DA2_POWER_DOWN_EN
  localparam bit PD_ON = 1'b1;
`else
  localparam bit PD_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [11:0] data_a [2];
  logic [11:0] data_b [2];
  logic [1:0]  pd_mode [2];
  logic [1:0]  busy, done, sync, sclk, dina, dinb;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      pmod_da2_spi #(
        .CLOCKS_PER_BIT              ((gi == 0) ? 4 : 2),
        .CLOCKS_BEFORE_DATA          (BEFORE),
        .CLOCKS_AFTER_DATA           (AFTER),
        .CLOCKS_BETWEEN_TRANSACTIONS (BETWEEN)
      ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid[gi]),
        .in_ready (in_ready[gi]),
        .data_a   (data_a[gi]),
        .data_b   (data_b[gi]),
`ifdef DA2_POWER_DOWN_EN
        .pd_mode  (pd_mode[gi]),
`endif
        .busy     (busy[gi]),
        .done     (done[gi]),
        .sync     (sync[gi]),
        .sclk     (sclk[gi]),
        .dina     (dina[gi]),
        .dinb     (dinb[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: cycles since transfer (-1 when idle), predicted in_ready, frames in flight.
  int          k_m [2];
  bit          ready_m [2];
  logic [15:0] mf_a [2];
  logic [15:0] mf_b [2];
  // Observed-frame bookkeeping.
  logic [15:0] cap_a [2];
  logic [15:0] cap_b [2];
  int          falls [2];
  int          dones [2];
  bit          prev_sclk [2];
  int          hi_run [2];
  bit          seen_low [2];

  typedef struct {
    int          inst;
    logic [11:0] a;
    logic [11:0] b;
    logic [1:0]  pd;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    int          exp_cycles;
  } vec_t;
  vec_t vecs [5];

  function automatic int per(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int hold_len(input int i);
    return (AFTER > per(i)) ? AFTER - per(i) : 1;
  endfunction

  function automatic int frame_len(input int i);
    return BEFORE + 16 * per(i) + hold_len(i) + BETWEEN;
  endfunction

  task automatic chk(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s[%0d] got %0h expected %0h (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      k_m[i] = -1;
      ready_m[i] = 1'b0;
      seen_low[i] = 1'b0;
      hi_run[i] = 0;
    end
  endtask

  task automatic compare(input int i);
    int k, p, shift_end, gap_start, bi;
    k = k_m[i];
    p = per(i);
    shift_end = BEFORE + 16 * p;
    gap_start = shift_end + hold_len(i);
    chk("sync", i, 16'(sync[i]), 16'(!(k >= 0 && k < gap_start)));
    chk("sclk", i, 16'(sclk[i]), 16'(!(k >= BEFORE && k < shift_end && ((k - BEFORE) % p) >= p / 2)));
    chk("busy", i, 16'(busy[i]), 16'(k >= 0));
    chk("done", i, 16'(done[i]), 16'(k == gap_start));
    chk("in_ready", i, 16'(in_ready[i]), 16'(ready_m[i]));
    if (k >= BEFORE && k < shift_end) begin
      bi = (k - BEFORE) / p;
      chk("dina_bit", i, 16'(dina[i]), 16'(mf_a[i][15 - bi]));
      chk("dinb_bit", i, 16'(dinb[i]), 16'(mf_b[i][15 - bi]));
    end else if (k < 0 || k >= gap_start) begin
      chk("dina_idle", i, 16'(dina[i]), 16'd0);
      chk("dinb_idle", i, 16'(dinb[i]), 16'd0);
    end
  endtask

  task automatic tick();
    bit          xfer [2];
    logic [15:0] nf_a [2];
    logic [15:0] nf_b [2];
    for (int i = 0; i < 2; i++) begin
      xfer[i] = in_valid[i] && ready_m[i] && !rst;
      nf_a[i] = {2'b00, PD_ON ? pd_mode[i] : 2'b00, data_a[i]};
      nf_b[i] = {2'b00, PD_ON ? pd_mode[i] : 2'b00, data_b[i]};
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        k_m[i] = -1;
        ready_m[i] = 1'b0;
      end else if (xfer[i]) begin
        k_m[i] = 0;
        ready_m[i] = 1'b0;
        mf_a[i] = nf_a[i];
        mf_b[i] = nf_b[i];
        cap_a[i] = '0;
        cap_b[i] = '0;
        falls[i] = 0;
        dones[i] = 0;
        $display("xfer inst %0d frame_a %h frame_b %h", i, nf_a[i], nf_b[i]);
      end else if (k_m[i] >= 0) begin
        k_m[i]++;
        if (k_m[i] == frame_len(i)) begin
          k_m[i] = -1;
          ready_m[i] = 1'b1;
        end
      end else begin
        ready_m[i] = 1'b1;
      end
      compare(i);
      if (prev_sclk[i] && !sclk[i]) begin
        cap_a[i] = {cap_a[i][14:0], dina[i]};
        cap_b[i] = {cap_b[i][14:0], dinb[i]};
        falls[i]++;
      end
      prev_sclk[i] = sclk[i];
      if (done[i]) begin
        dones[i]++;
        chk("frame_a_model", i, cap_a[i], mf_a[i]);
        chk("frame_b_model", i, cap_b[i], mf_b[i]);
        chk("sclk_falls", i, 16'(falls[i]), 16'd16);
      end
      if (sync[i]) begin
        hi_run[i]++;
      end else begin
        if (hi_run[i] > 0 && seen_low[i])
          chk("sync_gap_ok", i, 16'(hi_run[i] >= BETWEEN), 16'd1);
        if (hi_run[i] > 0) seen_low[i] = 1'b1;
        hi_run[i] = 0;
      end
    end
  endtask

  task automatic send(input int vi);
    int i, n;
    i = vecs[vi].inst;
    n = 0;
    while (!in_ready[i] && n < 300) begin
      tick();
      n++;
    end
    chk("ready_wait", i, 16'(in_ready[i]), 16'd1);
    in_valid[i] = 1'b1;
    data_a[i] = vecs[vi].a;
    data_b[i] = vecs[vi].b;
    pd_mode[i] = vecs[vi].pd;
    tick();
    in_valid[i] = 1'b0;
    data_a[i] = 12'($urandom_range(0, 4095));
    data_b[i] = 12'($urandom_range(0, 4095));
    pd_mode[i] = 2'($urandom_range(0, 3));
    n = 0;
    while (busy[i] && n < 300) begin
      n++;
      tick();
    end
    chk("vec_frame_a", i, cap_a[i], vecs[vi].exp_a);
    chk("vec_frame_b", i, cap_b[i], vecs[vi].exp_b);
    chk("vec_done_count", i, 16'(dones[i]), 16'd1);
    chk("vec_frame_cycles", i, 16'(n), 16'(vecs[vi].exp_cycles));
    $display("vec %0d inst %0d a=%h b=%h -> dina %h dinb %h cycles %0d",
             vi, i, vecs[vi].a, vecs[vi].b, cap_a[i], cap_b[i], n);
  endtask

  initial begin
    vecs[0] = '{0, 12'hA5C, 12'h3F0, 2'd0, 16'h0A5C, 16'h03F0, 79};
    vecs[1] = '{0, 12'hFFF, 12'h000, 2'd3, PD_ON ? 16'h3FFF : 16'h0FFF, PD_ON ? 16'h3000 : 16'h0000, 79};
    vecs[2] = '{1, 12'h001, 12'h800, 2'd0, 16'h0001, 16'h0800, 49};
    vecs[3] = '{1, 12'hABC, 12'h123, 2'd1, PD_ON ? 16'h1ABC : 16'h0ABC, PD_ON ? 16'h1123 : 16'h0123, 49};
    vecs[4] = '{0, 12'h800, 12'h001, 2'd2, PD_ON ? 16'h2800 : 16'h0800, PD_ON ? 16'h2001 : 16'h0001, 79};

    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      data_a[i] = '0;
      data_b[i] = '0;
      pd_mode[i] = '0;
      prev_sclk[i] = 1'b1;
      cap_a[i] = '0;
      cap_b[i] = '0;
      falls[i] = 0;
      dones[i] = 0;
    end
    rst = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // Idle after reset.
    repeat (50) tick();

    // Table of single frames on both instances.
    for (int v = 0; v < 5; v++) send(v);

    // Back-to-back with valid held high and data changing every cycle.
    for (int c = 0; c < 250; c++) begin
      in_valid[0] = 1'b1;
      data_a[0] = 12'($urandom_range(0, 4095));
      data_b[0] = 12'($urandom_range(0, 4095));
      pd_mode[0] = 2'($urandom_range(0, 3));
      tick();
    end
    in_valid[0] = 1'b0;
    repeat (100) tick();

    // Reset during bit 7 of a frame.
    send(0);
    in_valid[0] = 1'b1;
    data_a[0] = 12'h5A5;
    data_b[0] = 12'hC3C;
    tick();
    in_valid[0] = 1'b0;
    for (int n = 0; n < 200 && k_m[0] != BEFORE + 8 * 4 + 1; n++) tick();
    chk("reached_bit7", 0, 16'(k_m[0]), 16'(BEFORE + 8 * 4 + 1));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_sync", 0, 16'(sync[0]), 16'd1);
    chk("rst_sclk", 0, 16'(sclk[0]), 16'd1);
    chk("rst_dina", 0, 16'(dina[0]), 16'd0);
    chk("rst_busy", 0, 16'(busy[0]), 16'd0);
    chk("rst_ready", 0, 16'(in_ready[0]), 16'd0);
    repeat (2) tick();
    rst = 1'b0;
    send(0);
    send(2);

    // Random valid pattern on both instances.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = ($urandom_range(0, 3) == 0);
        data_a[i] = 12'($urandom_range(0, 4095));
        data_b[i] = 12'($urandom_range(0, 4095));
        pd_mode[i] = 2'($urandom_range(0, 3));
      end
      tick();
    end
    in_valid = '0;
    repeat (120) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
